// File: rtl/res_sched.sv
// res_sched: merges branch resolutions from two requesters into one in-order
// stream for the branch predictor, through a small resolution FIFO.
// Optional feature macro: RES_SCHED_BYPASS_EN. When it is defined, a lone
// resolution arriving at an empty FIFO is forwarded to res_o in the same cycle.
package res_sched_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic [XLEN-1:0] pc;
  } resolution_t;
endpackage

module res_sched
  import res_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     res0_valid_i,
  input  logic                     res1_valid_i,
  input  logic                     res0_taken_i,
  input  logic                     res1_taken_i,
  input  logic [XLEN-1:0]          res0_pc_i,
  input  logic [XLEN-1:0]          res1_pc_i,
  output logic                     res0_ready_o,
  output logic                     res1_ready_o,
  output resolution_t              res_o,
  output logic                     pred_flush_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic            rr_q;
  logic            pred_flush_q;

  // Storage is deliberately not reset; only occupancy/pointer state is.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic            taken_mem [DEPTH];

  logic [CW-1:0]   free;
  logic            run_ok;
  logic            ready0;
  logic            ready1;
  logic            single;
  logic            wr0;
  logic            wr1;
  logic            pop;
  logic            byp;
  logic            store0;
  logic            store1;
  logic [CW-1:0]   push_n;
  logic [AW-1:0]   wr1_idx;
  resolution_t     res;

  // Arbitration, bypass decision and FIFO head presentation.
  always_comb begin
    // Free slots include the slot released by this cycle's pop.
    free   = CW'(DEPTH) - count_q + {{(CW-1){1'b0}}, (count_q != {CW{1'b0}})};
    run_ok = (state_q == ST_RUN) && !flush_i && !rst_i;
    ready0 = 1'b0;
    ready1 = 1'b0;
    single = 1'b0;
    if (run_ok) begin
      if (free >= CW'(2)) begin
        ready0 = 1'b1;
        ready1 = 1'b1;
      end else if (free == CW'(1)) begin
        single = 1'b1;
        if (rr_q) begin
          ready1 = 1'b1;
        end else begin
          ready0 = 1'b1;
        end
      end else begin
        ready0 = 1'b0;
        ready1 = 1'b0;
      end
    end else begin
      ready0 = 1'b0;
      ready1 = 1'b0;
    end

    wr0 = res0_valid_i && ready0;
    wr1 = res1_valid_i && ready1;
    // The predictor never stalls, so a visible head is always consumed.
    pop = (count_q != {CW{1'b0}}) && (state_q == ST_RUN) && !flush_i;

`ifdef RES_SCHED_BYPASS_EN
    byp = (count_q == {CW{1'b0}}) && run_ok && (wr0 ^ wr1);
`else
    byp = 1'b0;
`endif

    store0  = wr0 && !byp;
    store1  = wr1 && !byp;
    push_n  = CW'(store0) + CW'(store1);
    // Port 0 is older, so it takes the first free slot.
    wr1_idx = wr_ptr_q + (store0 ? AW'(1) : AW'(0));

    res.valid = (count_q != {CW{1'b0}});
    res.taken = taken_mem[rd_ptr_q];
    res.pc    = pc_mem[rd_ptr_q];
    if (byp) begin
      res.valid = 1'b1;
      res.taken = wr0 ? res0_taken_i : res1_taken_i;
      res.pc    = wr0 ? res0_pc_i    : res1_pc_i;
    end else begin
      res.valid = res.valid && !rst_i;
    end
  end

  // Control FSM: run/flush state, occupancy, pointers and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      count_q      <= {CW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      rr_q         <= 1'b0;
      pred_flush_q <= 1'b0;
    end else if (flush_i) begin
      state_q      <= ST_FLUSH;
      count_q      <= {CW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      pred_flush_q <= 1'b1;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          state_q      <= ST_RUN;
          pred_flush_q <= 1'b0;
        end
        ST_RUN: begin
          pred_flush_q <= 1'b0;
          count_q      <= count_q + push_n - CW'(pop);
          wr_ptr_q     <= wr_ptr_q + AW'(push_n);
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
          end
          if (single && (wr0 || wr1)) begin
            rr_q <= ~rr_q;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          pred_flush_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage writes, port 0 ahead of port 1.
  always_ff @(posedge clk_i) begin
    if (store0) begin
      pc_mem[wr_ptr_q]    <= res0_pc_i;
      taken_mem[wr_ptr_q] <= res0_taken_i;
    end
    if (store1) begin
      pc_mem[wr1_idx]    <= res1_pc_i;
      taken_mem[wr1_idx] <= res1_taken_i;
    end
  end

  assign res0_ready_o = ready0;
  assign res1_ready_o = ready1;
  assign res_o        = res;
  assign pred_flush_o = pred_flush_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_res_sched.sv
// Directed self-checking bench for res_sched (DEPTH = 4). Expectations for the
// RES_SCHED_BYPASS_EN build are selected with the same macro.
module tb_res_sched;
  import res_sched_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              res0_valid_i;
  logic              res1_valid_i;
  logic              res0_taken_i;
  logic              res1_taken_i;
  logic [XLEN-1:0]   res0_pc_i;
  logic [XLEN-1:0]   res1_pc_i;
  logic              res0_ready_o;
  logic              res1_ready_o;
  resolution_t       res_o;
  logic              pred_flush_o;
  logic [2:0]        count_o;

  int n_tests = 0;
  int n_fail  = 0;

  res_sched #(.DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .res0_valid_i (res0_valid_i),
    .res1_valid_i (res1_valid_i),
    .res0_taken_i (res0_taken_i),
    .res1_taken_i (res1_taken_i),
    .res0_pc_i    (res0_pc_i),
    .res1_pc_i    (res1_pc_i),
    .res0_ready_o (res0_ready_o),
    .res1_ready_o (res1_ready_o),
    .res_o        (res_o),
    .pred_flush_o (pred_flush_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle values for the saturation / alternation stream.
  int          exp_cnt [6] = '{0, 2, 3, 4, 4, 4};
  logic        exp_vld [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] exp_pc  [6] = '{32'h0, 32'h200, 32'h300, 32'h200, 32'h300, 32'h200};
  logic        exp_r0  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        exp_r1  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    res0_valid_i = 1'b0; res1_valid_i = 1'b0;
    res0_taken_i = 1'b0; res1_taken_i = 1'b0;
    res0_pc_i = '0; res1_pc_i = '0;

    // Reset state with requesters active
    @(negedge clk_i);
    res0_valid_i = 1'b1; res1_valid_i = 1'b1;
    #1;
    check("rst_ready0", 32'(res0_ready_o), 32'd0);
    check("rst_ready1", 32'(res1_ready_o), 32'd0);
    check("rst_valid",  32'(res_o.valid),  32'd0);
    check("rst_count",  32'(count_o),      32'd0);
    check("rst_pflush", 32'(pred_flush_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; res0_valid_i = 1'b0; res1_valid_i = 1'b0;

    // Single resolution into an empty FIFO
    @(negedge clk_i);
    res0_valid_i = 1'b1; res0_pc_i = 32'h100; res0_taken_i = 1'b1;
    #1;
    check("single_ready0", 32'(res0_ready_o), 32'd1);
`ifdef RES_SCHED_BYPASS_EN
    check("byp_valid", 32'(res_o.valid), 32'd1);
    check("byp_pc",    res_o.pc,         32'h100);
    check("byp_taken", 32'(res_o.taken), 32'd1);
`else
    check("single_valid_same", 32'(res_o.valid), 32'd0);
`endif
    @(negedge clk_i);
    res0_valid_i = 1'b0;
    #1;
`ifdef RES_SCHED_BYPASS_EN
    check("byp_next_valid", 32'(res_o.valid), 32'd0);
    check("byp_next_count", 32'(count_o),      32'd0);
`else
    check("single_valid", 32'(res_o.valid), 32'd1);
    check("single_pc",    res_o.pc,         32'h100);
    check("single_taken", 32'(res_o.taken), 32'd1);
    check("single_count", 32'(count_o),     32'd1);
`endif
    @(negedge clk_i);
    #1;
    check("single_drain_count", 32'(count_o),     32'd0);
    check("single_drain_valid", 32'(res_o.valid), 32'd0);

    // Both ports every cycle: ordering, saturation, throttling, alternation
    res0_pc_i = 32'h200; res0_taken_i = 1'b0;
    res1_pc_i = 32'h300; res1_taken_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      res0_valid_i = 1'b1; res1_valid_i = 1'b1;
      #1;
      check($sformatf("stream%0d_count", i),  32'(count_o),      32'(exp_cnt[i]));
      check($sformatf("stream%0d_valid", i),  32'(res_o.valid),  32'(exp_vld[i]));
      check($sformatf("stream%0d_ready0", i), 32'(res0_ready_o), 32'(exp_r0[i]));
      check($sformatf("stream%0d_ready1", i), 32'(res1_ready_o), 32'(exp_r1[i]));
      if (exp_vld[i]) begin
        check($sformatf("stream%0d_pc", i),    res_o.pc,         exp_pc[i]);
        check($sformatf("stream%0d_taken", i), 32'(res_o.taken), (exp_pc[i] == 32'h300) ? 32'd1 : 32'd0);
      end
    end

    // Drain one entry to reach count 3, then flush with both ports valid
    @(negedge clk_i);
    res0_valid_i = 1'b0; res1_valid_i = 1'b0;
    #1;
    check("pre_flush_count4", 32'(count_o), 32'd4);
    @(negedge clk_i);
    flush_i = 1'b1; res0_valid_i = 1'b1; res1_valid_i = 1'b1;
    #1;
    check("flush_count3", 32'(count_o),      32'd3);
    check("flush_ready0", 32'(res0_ready_o), 32'd0);
    check("flush_ready1", 32'(res1_ready_o), 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    check("fst_count",  32'(count_o),      32'd0);
    check("fst_pflush", 32'(pred_flush_o), 32'd1);
    check("fst_valid",  32'(res_o.valid),  32'd0);
    check("fst_ready0", 32'(res0_ready_o), 32'd0);
    check("fst_ready1", 32'(res1_ready_o), 32'd0);
    @(negedge clk_i);
    res0_valid_i = 1'b0; res1_valid_i = 1'b0;
    #1;
    check("run_pflush", 32'(pred_flush_o), 32'd0);
    check("run_count",  32'(count_o),      32'd0);
    check("run_ready0", 32'(res0_ready_o), 32'd1);
    check("run_ready1", 32'(res1_ready_o), 32'd1);

    // Back-to-back flush keeps pred_flush high
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("reflush_pflush1", 32'(pred_flush_o), 32'd1);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    check("reflush_pflush2", 32'(pred_flush_o), 32'd1);
    check("reflush_ready0",  32'(res0_ready_o), 32'd0);
    @(negedge clk_i);
    #1;
    check("reflush_end", 32'(pred_flush_o), 32'd0);

    // Reset pulse with two entries in flight
    @(negedge clk_i);
    res0_valid_i = 1'b1; res1_valid_i = 1'b1;
    #1;
    check("prerst_ready0", 32'(res0_ready_o), 32'd1);
    @(negedge clk_i);
    res0_valid_i = 1'b0; res1_valid_i = 1'b0;
    #1;
    check("prerst_count2", 32'(count_o), 32'd2);
    rst_i = 1'b1;
    #1;
    check("midrst_count",  32'(count_o),      32'd0);
    check("midrst_valid",  32'(res_o.valid),  32'd0);
    check("midrst_ready0", 32'(res0_ready_o), 32'd0);
    check("midrst_ready1", 32'(res1_ready_o), 32'd0);
    @(negedge clk_i);
    res0_valid_i = 1'b1; res1_valid_i = 1'b1;
    #1;
    check("inrst_ready0", 32'(res0_ready_o), 32'd0);
    check("inrst_ready1", 32'(res1_ready_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; res0_valid_i = 1'b0; res1_valid_i = 1'b0;
    #1;
    check("postrst_valid", 32'(res_o.valid), 32'd0);
    check("postrst_count", 32'(count_o),     32'd0);
    @(negedge clk_i);
    #1;
    check("postrst_valid2", 32'(res_o.valid), 32'd0);
    check("postrst_count2", 32'(count_o),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/res_sched.md
RES_SCHED -- requirements
Module: res_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, resolution FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush_i  input  1  pipeline flush request.
REQ-005 SHALL have ports res0_valid_i/res1_valid_i  input  1 each  requester resolution valid.
REQ-006 SHALL have ports res0_taken_i/res1_taken_i  input  1 each  branch outcome.
REQ-007 SHALL have ports res0_pc_i/res1_pc_i  input  XLEN each  branch PC.
REQ-008 SHALL have ports res0_ready_o/res1_ready_o  output  1 each  accept; transfer = valid && ready.
REQ-009 SHALL have port res_o  output  resolution_t (valid, taken, pc)  resolution to predictor.
REQ-010 SHALL have port pred_flush_o  output  1  predictor history/PHT flush.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-012 SHALL present the FIFO head on res_o combinationally; res_o.valid = (count_o != 0).
REQ-013 SHALL pop the head every cycle res_o.valid is 1 (predictor never backpressures).
REQ-014 SHALL compute free = DEPTH - count_o + (count_o != 0 ? 1 : 0), i.e. include same-cycle pop.
REQ-015 SHALL assert both readies when free >= 2 and state is RUN.
REQ-016 SHALL, when free == 1 and state is RUN, assert ready only for the port selected by the round-robin pointer rr_q; other port ready low.
REQ-017 SHALL, when free == 0 or state is not RUN, deassert both readies.
REQ-018 SHALL toggle rr_q to the non-granted port after any single-slot grant; rr_q unchanged otherwise.
REQ-019 SHALL, when both ports transfer in one cycle, write port 0 before port 1 (port 0 is older).
REQ-020 SHALL make an accepted entry visible on res_o the cycle after acceptance, behind older entries.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; count_o never exceeds DEPTH and never underflows.
REQ-022 SHALL implement FSM states RUN and FLUSH; RUN->FLUSH when flush_i=1; FLUSH->RUN unconditionally next cycle.
REQ-023 SHALL, in any cycle flush_i=1, deassert both readies (no transfer) and suppress the pop.
REQ-024 SHALL, on the edge where flush_i=1 is sampled, clear FIFO (count_o=0, pointers 0) and set pred_flush_o=1 for exactly the FLUSH cycle.
REQ-025 SHALL drive res_o.valid=0 during FLUSH; readies stay low in FLUSH.
REQ-026 SHALL treat flush_i=1 while in FLUSH as a new flush: remain in FLUSH, pred_flush_o held 1.

Reset
REQ-027 SHALL, on rst_i=1 (asynchronously), set state RUN, count_o=0, pointers 0, rr_q=port 0, pred_flush_o=0.
REQ-028 SHALL hold res_o.valid=0, both readies 0 while rst_i=1; entries in flight at reset are discarded.
REQ-029 SHALL leave FIFO storage contents unreset; only valid/pointer state is reset.

Configuration
REQ-030 SHALL support macro RES_SCHED_BYPASS_EN.
REQ-031 SHALL, with RES_SCHED_BYPASS_EN defined, when count_o=0, state RUN, and exactly one port transfers, drive that resolution on res_o in the same cycle and not store it.
REQ-032 SHALL, without RES_SCHED_BYPASS_EN, always store accepted entries (1-cycle accept-to-res_o latency).
REQ-033 SHALL, with the macro, still store both entries when both ports transfer with empty FIFO (no bypass).

Verification
REQ-034 SHALL cover: empty FIFO, res0 valid pc=0x100 taken=1 -> res_o.valid=1, pc=0x100, taken=1 next cycle (same cycle with RES_SCHED_BYPASS_EN), count_o back to 0.
REQ-035 SHALL cover: both ports valid (pc 0x200, 0x300) every cycle, DEPTH=4 -> order 0x200 then 0x300 on res_o, count_o saturates at 4 with readies throttled per REQ-014..016.
REQ-036 SHALL cover: count_o=4 with pop pending, both valid -> free=1, grant alternates port0/port1 on successive cycles.
REQ-037 SHALL cover: count_o=3, flush_i=1 with both valid -> no transfer, next cycle count_o=0, pred_flush_o=1, res_o.valid=0, then RUN.
REQ-038 SHALL cover: rst_i pulse mid-stream with count_o=2 -> count_o=0, readies 0 during reset, no stale res_o.valid after release.
